// File: rtl/hdc_pkg.sv
// Shared HDC constants and the chunk collector state type.
// The encoder slice mux uses the same dimension constants.
package hdc_pkg;

   localparam int HV_DIM      = 5000;
   localparam int DIMS_PER_CC = 500;
   localparam int NUM_CHUNKS  = HV_DIM / DIMS_PER_CC;
   localparam int CTR_W       = $clog2(NUM_CHUNKS);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } collect_state_e;

endpackage

// File: rtl/hv_chunk_wr_decode.sv
// Turns the chunk counter and an accept strobe into one-hot slot write enables.
// This is the mirror image of the encoder's chunk-select mux.
module hv_chunk_wr_decode #(
   parameter int NUM_CHUNKS = 10,
   parameter int CTR_W      = 4
) (
   input  logic [CTR_W-1:0]      ctr,
   input  logic                  accept,
   output logic [NUM_CHUNKS-1:0] wr_en
);

   // An out-of-range counter matches no slot, so nothing is written.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
         if (accept && (ctr == CTR_W'(i))) begin
            wr_en[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/enc_demux_collect.sv
// Reassembles a full hypervector from DIMS_PER_CC-wide chunks under valid/ready.
// Chunk k lands in hv_out[k*DIMS_PER_CC +: DIMS_PER_CC], with chunk 0 in the LSBs.
module enc_demux_collect #(
   parameter int HV_DIM        = hdc_pkg::HV_DIM,
   parameter int DIMS_PER_CC   = hdc_pkg::DIMS_PER_CC,
   localparam int NUM_CHUNKS   = HV_DIM / DIMS_PER_CC,
   localparam int CTR_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             chunk_in [DIMS_PER_CC],
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CTR_W-1:0] ctr,
   output logic             hv_out [HV_DIM],
   output logic             out_valid,
   input  logic             out_ready
);

   import hdc_pkg::collect_state_e;
   import hdc_pkg::EMPTY;
   import hdc_pkg::FILL;
   import hdc_pkg::FULL;

   localparam logic [CTR_W-1:0] LAST_SLOT = CTR_W'(NUM_CHUNKS - 1);

   collect_state_e        state;
   logic                  accept;
   logic                  slot_write;
   logic [NUM_CHUNKS-1:0] wr_en;

   assign in_ready   = (state != FULL);
   assign accept     = in_valid && in_ready;
   assign slot_write = accept && !flush;

   hv_chunk_wr_decode #(
      .NUM_CHUNKS (NUM_CHUNKS),
      .CTR_W      (CTR_W)
   ) u_wr_decode (
      .ctr    (ctr),
      .accept (slot_write),
      .wr_en  (wr_en)
   );

   // Flush beats both accept and release; an out-of-range ctr or stray state encoding falls back to EMPTY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         ctr       <= '0;
         out_valid <= 1'b0;
      end else if (flush || (ctr > LAST_SLOT)) begin
         state     <= EMPTY;
         ctr       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            EMPTY, FILL: begin
               if (accept) begin
                  if (ctr == LAST_SLOT) begin
                     ctr       <= '0;
                     state     <= FULL;
                     out_valid <= 1'b1;
                  end else begin
                     ctr       <= ctr + 1'b1;
                     state     <= FILL;
                  end
               end
            end
            FULL: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            default: begin
               state     <= EMPTY;
               ctr       <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Release and flush leave the stored bits alone; later chunks overwrite them slot by slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HV_DIM; i++) begin
            hv_out[i] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (wr_en[k]) begin
               for (int j = 0; j < DIMS_PER_CC; j++) begin
                  hv_out[k*DIMS_PER_CC + j] <= chunk_in[j];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_enc_demux_collect.sv
// Self-checking bench for enc_demux_collect: a vector table for the basic fill/release
// flow, then hand-written sequences for gaps, backpressure, flush and async reset.
module tb_enc_demux_collect;

   import hdc_pkg::*;

   localparam int HV_ZERO  = 0;
   localparam int HV_ALT   = 1;
   localparam int HV_WALK  = 2;
   localparam int HV_FLMIX = 3;
   localparam int HV_STRIPE = 4;
   localparam int HV_ONES  = 5;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             chunk_in [DIMS_PER_CC];
   logic             in_valid;
   logic             in_ready;
   logic [CTR_W-1:0] ctr;
   logic             hv_out [HV_DIM];
   logic             out_valid;
   logic             out_ready;

   int n_checks;
   int n_fail;

   typedef struct {
      logic in_valid;
      logic flush;
      logic out_ready;
      logic chunk_bit;
      int   exp_ctr;
      logic exp_ov;
      logic exp_ir;
   } vec_t;

   vec_t vecs [15];

   enc_demux_collect dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .chunk_in  (chunk_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ctr       (ctr),
      .hv_out    (hv_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic expBit(input int mode, input int i);
      int k;
      int j;
      k = i / DIMS_PER_CC;
      j = i % DIMS_PER_CC;
      case (mode)
         HV_ALT:    return logic'(k % 2);
         HV_WALK:   return logic'(j == k);
         HV_FLMIX:  return (k < 4) ? 1'b1 : logic'(j == k);
         HV_STRIPE: return logic'((j % 10) == k);
         HV_ONES:   return 1'b1;
         default:   return 1'b0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkHv(input string name, input int mode);
      int errs;
      int first;
      errs  = 0;
      first = -1;
      for (int i = 0; i < HV_DIM; i++) begin
         if (hv_out[i] !== expBit(mode, i)) begin
            if (errs == 0) first = i;
            errs++;
         end
      end
      n_checks++;
      if (errs != 0) begin
         n_fail++;
         $display("[TB] FAIL %s: %0d wrong bits, first at %0d got %b expected %b", name, errs, first,
                  hv_out[first], expBit(mode, first));
      end
   endtask

   task automatic applyStimulus(input logic v, input logic f, input logic ordy);
      in_valid  = v;
      flush     = f;
      out_ready = ordy;
   endtask

   task automatic setChunkConst(input logic b);
      for (int j = 0; j < DIMS_PER_CC; j++) chunk_in[j] = b;
   endtask

   task automatic setChunkWalk(input int k);
      for (int j = 0; j < DIMS_PER_CC; j++) chunk_in[j] = (j == k);
   endtask

   task automatic setChunkStripe(input int k);
      for (int j = 0; j < DIMS_PER_CC; j++) chunk_in[j] = ((j % 10) == k);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      setChunkConst(1'b0);

      // Table: chunk k is all k[0], with a gap, an ignored out_ready, backpressure and release.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 9, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset ctr", int'(ctr), 0);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset in_ready", int'(in_ready), 1);
      checkHv("reset hv_out", HV_ZERO);
      rst_n = 1'b1;

      for (int v = 0; v < 15; v++) begin
         applyStimulus(vecs[v].in_valid, vecs[v].flush, vecs[v].out_ready);
         setChunkConst(vecs[v].chunk_bit);
         stepCycle();
         checkOutput($sformatf("vec%0d ctr", v), int'(ctr), vecs[v].exp_ctr);
         checkOutput($sformatf("vec%0d out_valid", v), int'(out_valid), int'(vecs[v].exp_ov));
         checkOutput($sformatf("vec%0d in_ready", v), int'(in_ready), int'(vecs[v].exp_ir));
         if (v == 11 || v == 14) checkHv($sformatf("vec%0d hv_out alt", v), HV_ALT);
      end

      // Walking pattern with random gaps overwrites every stale slot.
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         int gaps;
         gaps = int'($urandom_range(0, 2));
         repeat (gaps) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            stepCycle();
            checkOutput("gap ctr", int'(ctr), k);
            checkOutput("gap in_ready", int'(in_ready), 1);
         end
         setChunkWalk(k);
         applyStimulus(1'b1, 1'b0, 1'b0);
         stepCycle();
         checkOutput("walk ctr", int'(ctr), (k + 1) % NUM_CHUNKS);
         checkOutput("walk out_valid", int'(out_valid), (k == NUM_CHUNKS - 1) ? 1 : 0);
         checkOutput("walk in_ready", int'(in_ready), (k == NUM_CHUNKS - 1) ? 0 : 1);
      end
      checkHv("walk hv_out", HV_WALK);

      // Backpressure in FULL with a new chunk pushing in.
      setChunkConst(1'b1);
      repeat (5) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         stepCycle();
         checkOutput("hold in_ready", int'(in_ready), 0);
         checkOutput("hold out_valid", int'(out_valid), 1);
         checkOutput("hold ctr", int'(ctr), 0);
         checkHv("hold hv_out", HV_WALK);
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("release out_valid", int'(out_valid), 0);
      checkOutput("release in_ready", int'(in_ready), 1);
      checkOutput("release ctr", int'(ctr), 0);
      checkHv("release hv_out kept", HV_WALK);

      // Flush after 4 accepts drops the chunk presented alongside it.
      setChunkConst(1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         stepCycle();
         checkOutput("pre-flush ctr", int'(ctr), i + 1);
      end
      setChunkConst(1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("flush ctr", int'(ctr), 0);
      checkOutput("flush out_valid", int'(out_valid), 0);
      checkOutput("flush in_ready", int'(in_ready), 1);
      checkHv("flush hv_out", HV_FLMIX);
      stepCycle();
      checkOutput("post-flush ctr", int'(ctr), 0);

      for (int k = 0; k < NUM_CHUNKS; k++) begin
         setChunkStripe(k);
         applyStimulus(1'b1, 1'b0, 1'b0);
         stepCycle();
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("refill out_valid", int'(out_valid), 1);
      checkOutput("refill ctr", int'(ctr), 0);
      checkHv("refill hv_out", HV_STRIPE);
      applyStimulus(1'b0, 1'b0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("refill release out_valid", int'(out_valid), 0);

      // Async reset mid-cycle while chunk 7 is on the bus.
      setChunkConst(1'b1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         stepCycle();
      end
      checkOutput("pre-reset ctr", int'(ctr), 7);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("mid-fill reset ctr", int'(ctr), 0);
      checkOutput("mid-fill reset out_valid", int'(out_valid), 0);
      checkOutput("mid-fill reset in_ready", int'(in_ready), 1);
      checkHv("mid-fill reset hv_out", HV_ZERO);
      stepCycle();
      rst_n = 1'b1;

      for (int i = 0; i < NUM_CHUNKS; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         stepCycle();
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("ones out_valid", int'(out_valid), 1);
      checkHv("ones hv_out", HV_ONES);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("full reset ctr", int'(ctr), 0);
      checkOutput("full reset out_valid", int'(out_valid), 0);
      checkOutput("full reset in_ready", int'(in_ready), 1);
      checkHv("full reset hv_out", HV_ZERO);
      stepCycle();
      rst_n = 1'b1;
      stepCycle();
      checkOutput("after reset out_valid", int'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
